// File: rtl/instruction_queue_pkg.sv
// Shared configuration and entry types for the issue/write-back instruction queue.
// The entry is packed MSB-first as {unit_id, id, rd_addr}.
package instruction_queue_pkg;
  localparam int INSTRUCTION_QUEUE_DEPTH = 4;
  localparam int WB_UNITS_WIDTH          = 2;
  localparam int INSTR_ID_WIDTH          = 3;
  localparam int RD_ADDR_WIDTH           = 5;
  localparam int IQ_ENTRY_WIDTH          = WB_UNITS_WIDTH + INSTR_ID_WIDTH + RD_ADDR_WIDTH;

  typedef logic [INSTR_ID_WIDTH-1:0] instruction_id_t;

  typedef struct packed {
    logic [WB_UNITS_WIDTH-1:0] unit_id;
    instruction_id_t           id;
    logic [RD_ADDR_WIDTH-1:0]  rd_addr;
  } iq_entry_t;
endpackage

// File: rtl/instruction_queue.sv
// Shifting in-order tracking queue: slot 0 is youngest, highest valid slot is oldest.
// Any single slot may retire per cycle; the hole collapses on the same edge.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH          = INSTRUCTION_QUEUE_DEPTH,
  parameter int UNIT_W         = WB_UNITS_WIDTH,
  parameter int ID_W           = INSTR_ID_WIDTH,
  parameter int ENTRY_W        = UNIT_W + ID_W + RD_ADDR_WIDTH,
  parameter bit CHECK_PROTOCOL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         data_in,
  output logic                       ready,
  input  logic [DEPTH-1:0]           pop,
  output logic [DEPTH-1:0]           valid,
  output logic [DEPTH*ENTRY_W-1:0]   data_out,
  output logic [DEPTH-1:0]           shift_pop,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]   r_valid;
  logic [ENTRY_W-1:0] r_data [DEPTH];

  logic [DEPTH:0]     w_vac_ext;
  logic [DEPTH-1:0]   w_vacate;
  logic [DEPTH-1:0]   w_move;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) acc = acc + CNT_W'(v[i]);
    return acc;
  endfunction

  // Top-down vacate chain; the extra always-zero bit makes move[DEPTH-1]=0 fall out naturally.
  always_comb begin
    w_vac_ext        = '0;
    w_move           = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_move[i]    = w_vac_ext[i+1];
      w_vac_ext[i] = ~r_valid[i] | pop[i] | w_move[i];
    end
    w_vacate = w_vac_ext[DEPTH-1:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign shift_pop[gi] = w_move[gi] & r_valid[gi] & ~pop[gi];
      assign data_out[gi*ENTRY_W +: ENTRY_W] = r_data[gi];
    end
  endgenerate

  // A popped entry that is also in the moving region must not carry its valid upward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      if (w_vacate[0]) begin
        r_valid[0] <= push;
        r_data[0]  <= data_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_move[i-1]) begin
          r_valid[i] <= r_valid[i-1] & ~pop[i-1];
          r_data[i]  <= r_data[i-1];
        end else if (pop[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign ready = w_vacate[0];
  assign valid = r_valid;
  assign empty = ~|r_valid;
  assign count = popcount(r_valid);

  always_ff @(posedge clk) begin
    if (CHECK_PROTOCOL && !rst) begin
      assert (!(push && !ready)) else $error("instruction_queue: push dropped while full");
      assert ($onehot0(pop)) else $error("instruction_queue: more than one pop bit set");
      assert ((pop & ~r_valid) == '0) else $error("instruction_queue: pop of an empty slot");
    end
  end
endmodule

// File: tb/tb_instruction_queue.sv
// Table-driven bench for instruction_queue: each row drives one cycle, checks the
// combinational ready/shift_pop, and queues the expected post-edge state for checking.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = IQ_ENTRY_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 push;
  logic [EW-1:0]        data_in;
  logic                 ready;
  logic [DEPTH-1:0]     pop;
  logic [DEPTH-1:0]     valid;
  logic [DEPTH*EW-1:0]  data_out;
  logic [DEPTH-1:0]     shift_pop;
  logic                 empty;
  logic [2:0]           count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_queue #(.CHECK_PROTOCOL(1'b0)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .ready(ready),
    .pop(pop), .valid(valid), .data_out(data_out), .shift_pop(shift_pop),
    .empty(empty), .count(count)
  );

  typedef struct {
    logic          rst;
    logic          push;
    logic [EW-1:0] din;
    logic [3:0]    pop;
    logic          ready;
    logic [3:0]    shift;
    logic [3:0]    valid;
    logic [2:0]    count;
    logic [EW-1:0] slot [4];
  } vec_t;

  typedef struct {
    int            row;
    logic [3:0]    valid;
    logic [2:0]    count;
    logic [EW-1:0] slot [4];
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic iq_entry_t mk_entry(input int u, input int id, input int rd);
    iq_entry_t e;
    e.unit_id = WB_UNITS_WIDTH'(u);
    e.id      = instruction_id_t'(id);
    e.rd_addr = RD_ADDR_WIDTH'(rd);
    return e;
  endfunction

  function automatic vec_t row(input logic r, input logic p, input logic [EW-1:0] d,
                               input logic [3:0] pp, input logic rdy, input logic [3:0] sh,
                               input logic [3:0] v, input logic [2:0] c,
                               input logic [EW-1:0] s3, input logic [EW-1:0] s2,
                               input logic [EW-1:0] s1, input logic [EW-1:0] s0);
    vec_t t;
    t.rst = r; t.push = p; t.din = d; t.pop = pp; t.ready = rdy; t.shift = sh;
    t.valid = v; t.count = c;
    t.slot[3] = s3; t.slot[2] = s2; t.slot[1] = s1; t.slot[0] = s0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    logic [EW-1:0] got;
    rst = v.rst; push = v.push; data_in = v.din; pop = v.pop;
    #2;
    chk($sformatf("row%0d ready", idx), 64'(ready), 64'(v.ready));
    chk($sformatf("row%0d shift_pop", idx), 64'(shift_pop), 64'(v.shift));
    e.row = idx; e.valid = v.valid; e.count = v.count;
    for (int i = 0; i < 4; i++) e.slot[i] = v.slot[i];
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("row%0d valid", e.row), 64'(valid), 64'(e.valid));
    chk($sformatf("row%0d count", e.row), 64'(count), 64'(e.count));
    chk($sformatf("row%0d empty", e.row), 64'(empty), 64'(e.valid == 4'b0000));
    for (int i = 0; i < 4; i++) begin
      if (e.valid[i]) begin
        got = data_out[i*EW +: EW];
        chk($sformatf("row%0d slot%0d", e.row, i), 64'(got), 64'(e.slot[i]));
      end
    end
    $display("row %0d: rst=%b push=%b pop=%b -> valid=%b count=%0d", idx, v.rst, v.push,
             v.pop, valid, count);
  endtask

  logic [EW-1:0] A, B, C, D, E, F, G, H, P, Q, X, Z, N;

  initial begin
    A = mk_entry(1, 1, 1);  B = mk_entry(2, 2, 2);  C = mk_entry(3, 3, 3);
    D = mk_entry(0, 4, 4);  E = mk_entry(1, 5, 17); F = mk_entry(2, 6, 9);
    G = mk_entry(3, 7, 30); H = mk_entry(0, 0, 31); P = mk_entry(1, 2, 12);
    Q = mk_entry(2, 3, 21); X = mk_entry(3, 5, 6);  Z = mk_entry(3, 6, 27);
    N = '0;

    //              rst push din pop      rdy shift    valid    cnt  s3 s2 s1 s0
    tbl.push_back(row(0, 1, A, 4'b0000, 1, 4'b0000, 4'b0001, 1, N, N, N, A));
    tbl.push_back(row(0, 1, B, 4'b0000, 1, 4'b0001, 4'b0011, 2, N, N, A, B));
    tbl.push_back(row(0, 1, C, 4'b0000, 1, 4'b0011, 4'b0111, 3, N, A, B, C));
    tbl.push_back(row(0, 1, D, 4'b0000, 1, 4'b0111, 4'b1111, 4, A, B, C, D));
    tbl.push_back(row(0, 0, N, 4'b0000, 0, 4'b0000, 4'b1111, 4, A, B, C, D));
    tbl.push_back(row(0, 1, E, 4'b1000, 1, 4'b0111, 4'b1111, 4, B, C, D, E));
    tbl.push_back(row(0, 1, F, 4'b0000, 0, 4'b0000, 4'b1111, 4, B, C, D, E));
    tbl.push_back(row(0, 0, N, 4'b1000, 1, 4'b0111, 4'b1110, 3, C, D, E, N));
    tbl.push_back(row(0, 0, N, 4'b0100, 1, 4'b0010, 4'b1100, 2, C, E, N, N));
    tbl.push_back(row(0, 0, N, 4'b0001, 1, 4'b0000, 4'b1100, 2, C, E, N, N));
    tbl.push_back(row(0, 1, G, 4'b1000, 1, 4'b0100, 4'b1001, 2, E, N, N, G));
    tbl.push_back(row(0, 0, N, 4'b0001, 1, 4'b0000, 4'b1000, 1, E, N, N, N));
    tbl.push_back(row(0, 0, N, 4'b1000, 1, 4'b0000, 4'b0000, 0, N, N, N, N));
    tbl.push_back(row(0, 1, X, 4'b0000, 1, 4'b0000, 4'b0001, 1, N, N, N, X));
    tbl.push_back(row(0, 0, N, 4'b0000, 1, 4'b0001, 4'b0010, 1, N, N, X, N));
    tbl.push_back(row(0, 0, N, 4'b0000, 1, 4'b0010, 4'b0100, 1, N, X, N, N));
    tbl.push_back(row(0, 0, N, 4'b0000, 1, 4'b0100, 4'b1000, 1, X, N, N, N));
    tbl.push_back(row(0, 0, N, 4'b0000, 1, 4'b0000, 4'b1000, 1, X, N, N, N));
    tbl.push_back(row(0, 1, P, 4'b0000, 1, 4'b0000, 4'b1001, 2, X, N, N, P));
    tbl.push_back(row(0, 1, Q, 4'b0000, 1, 4'b0001, 4'b1011, 3, X, N, P, Q));
    tbl.push_back(row(0, 0, N, 4'b0000, 1, 4'b0011, 4'b1110, 3, X, P, Q, N));
    tbl.push_back(row(1, 1, Z, 4'b0000, 1, 4'b0000, 4'b0000, 0, N, N, N, N));
    tbl.push_back(row(0, 1, A, 4'b0000, 1, 4'b0000, 4'b0001, 1, N, N, N, A));
    tbl.push_back(row(0, 1, B, 4'b0000, 1, 4'b0001, 4'b0011, 2, N, N, A, B));
    tbl.push_back(row(0, 1, C, 4'b0000, 1, 4'b0011, 4'b0111, 3, N, A, B, C));
    tbl.push_back(row(0, 1, D, 4'b0000, 1, 4'b0111, 4'b1111, 4, A, B, C, D));
    tbl.push_back(row(0, 1, H, 4'b0010, 1, 4'b0001, 4'b1111, 4, A, B, D, H));

    rst = 1'b1; push = 1'b0; pop = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 64'(valid), 64'h0);
    chk("reset empty", 64'(empty), 64'h1);
    chk("reset count", 64'(count), 64'h0);
    chk("reset ready", 64'(ready), 64'h1);
    chk("reset shift_pop", 64'(shift_pop), 64'h0);
    chk("reset data_out", 64'(data_out), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // Full queue: ready must follow pop within the same cycle, with no register in between.
    rst = 1'b0; push = 1'b0; pop = 4'b0000;
    #1 chk("full no-pop ready", 64'(ready), 64'h0);
    pop = 4'b1000;
    #1 chk("full pop3 ready", 64'(ready), 64'h1);
    pop = 4'b0001;
    #1 chk("full pop0 ready", 64'(ready), 64'h1);
    chk("full pop0 shift_pop", 64'(shift_pop), 64'h0);
    pop = 4'b0000;
    #1 chk("full restored ready", 64'(ready), 64'h0);
    @(posedge clk); #1;
    chk("full hold count", 64'(count), 64'h4);
    $display("combinational ready sequence: valid=%b count=%0d", valid, count);

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
